call_scheduler: RTL and testbench
=================================

// Module: call_scheduler
// PURPOSE
//  Upstream request stage for the elevator movement logic. Debounces the three
//  call buttons, latches pending calls (drives the call LEDs), and selects the
//  goal floor with a direction-preserving (up/down sweep) policy.
//  Outputs led1..3 and goal_floor feed the movement controller. floor and
//  moving from that controller are fed back to clear served calls.
// PARAMETERS
//  DEBOUNCE_CYCLES  4      consecutive high samples before a press is accepted (>=1)
//  labelF1          2'b00  encoding of floor 1
//  labelF2          2'b01  encoding of floor 2
//  labelF3          2'b10  encoding of floor 3
// PORTS
//  clk             in   1  system clock; all state changes on posedge
//  reset           in   1  synchronous, active-high reset
//  button1..3      in   1  raw call buttons, active-high, asynchronous to clk (2-flop sync inside)
//  floor           in   2  current cabin floor (labelF1..F3); 2'b11 is invalid
//  moving          in   1  1 while the cabin is travelling or the door is closed for travel
//  sos_mode        in   1  emergency; cancels and blocks all calls
//  led1..3         out  1  pending-call latch per floor
//  goal_floor      out  2  floor the movement controller must head to
//  dir_up,dir_down out  1  current sweep direction; both 0 = idle
//  request_pending out  1  led1|led2|led3
// BEHAVIOUR
//  Reset (reset=1 at posedge): sync flops, debounce counters, latches, dir_* = 0.
//   State = IDLE. goal_floor = labelF1. Reset wins over every other input.
//  Sync/debounce: the 2-flop synchroniser output drives a per-button counter
//   (width clog2(DEBOUNCE_CYCLES+1)). The counter increments while the synced
//   input is 1, saturates at DEBOUNCE_CYCLES, and clears to 0 when the input is 0.
//   The press pulse fires on the one cycle the counter reaches DEBOUNCE_CYCLES.
//   Holding the button gives one pulse only.
//  Latch: a press pulse sets led_f on the next edge.
//   Clear condition: floor==label_f && moving==0 && floor valid. Clear wins over a
//   same-cycle set, so a call at the current stopped floor never lights.
//   sos_mode=1 clears all latches every cycle and suppresses sets.
//  Direction FSM (states IDLE, UP, DOWN). Evaluated only when moving==0, floor is
//   valid and sos_mode==0; otherwise state and goal_floor hold.
//   Pending above/below means any led strictly above/below floor.
//   IDLE: above -> UP; else below -> DOWN; else stay IDLE.
//   UP:   above -> stay UP; else below -> DOWN; else IDLE.
//   DOWN: below -> stay DOWN; else above -> UP; else IDLE.
//   If both above and below are pending from IDLE, UP is chosen.
//  goal_floor (registered, updated on the same edge as the FSM):
//   UP   -> nearest pending floor above (from F1 with F2 and F3 pending: F2).
//   DOWN -> nearest pending floor below.
//   IDLE -> current floor.
//   sos_mode=1 -> goal_floor <= floor (if valid) and FSM <= IDLE, regardless of moving.
//  dir_up = (state==UP), dir_down = (state==DOWN), decoded from state register.
//  Invalid floor (2'b11): no clears, no FSM step, goal held.
//  Latency: a button held high from cycle 0 -> sync output high at cycle 2 ->
//   pulse at cycle 2+DEBOUNCE_CYCLES-1 -> led at the next edge -> goal_floor one
//   edge after the led (if moving==0).
// TESTING
//  1. Reset, floor=F1, moving=0; hold button3 for 10 cycles (DEBOUNCE=4) ->
//     led3=1 at cycle 6, goal_floor=F3 and dir_up=1 at cycle 7; one set only.
//  2. Glitch: button2 high 3 cycles then low -> led2 stays 0; counter returns to 0.
//  3. floor=F2, state UP, led1 and led3 pending, moving=0 -> goal=F3.
//     Then floor=F3, moving=0 -> led3 clears, state DOWN, goal=F1.
//  4. floor=F1, moving=0; press button1 -> led1 never asserts; goal stays F1; state IDLE.
//  5. led2, led3 pending; assert sos_mode one cycle -> all leds 0, state IDLE,
//     goal=floor. A press during sos is ignored.
//  6. reset asserted mid-sweep (moving=1, led3=1) -> next edge: all outputs at
//     reset values; floor=2'b11 afterwards -> no state change.

Source files
------------

// File: rtl/call_scheduler.sv
// Elevator call front end: synchronises and debounces the three call buttons,
// latches pending calls and picks the goal floor with an up/down sweep policy.
module call_scheduler #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [1:0] labelF1         = 2'b00,
    parameter logic [1:0] labelF2         = 2'b01,
    parameter logic [1:0] labelF3         = 2'b10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       button1_i,
    input  logic       button2_i,
    input  logic       button3_i,
    input  logic [1:0] floor_i,
    input  logic       moving_i,
    input  logic       sos_mode_i,
    output logic       led1_o,
    output logic       led2_o,
    output logic       led3_o,
    output logic [1:0] goal_floor_o,
    output logic       dir_up_o,
    output logic       dir_down_o,
    output logic       request_pending_o
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] cntMax = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, UP, DOWN} dirState_e;

    logic [2:0]    buttons;
    logic [2:0]    sync1_q, sync2_q;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    press;
    logic [2:0]    ledClr;
    logic [2:0]    led_q, led_d;
    logic          floorValid;
    logic [1:0]    floorIdx;
    logic          above, below;
    logic [1:0]    nearUp, nearDown;
    dirState_e     state_q, state_d;
    logic [1:0]    goal_q, goal_d;

    assign buttons = {button3_i, button2_i, button1_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            led_q   <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
            led_q   <= led_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // The press pulse fires in the cycle before the counter saturates, so a held button yields one pulse.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            press[i] = 1'b0;
            if (sync2_q[i]) begin
                cnt_d[i] = (cnt_q[i] == cntMax) ? cnt_q[i] : cnt_q[i] + 1'b1;
                press[i] = (cnt_q[i] == cntMax - 1'b1);
            end
        end
    end

    always_comb begin
        floorValid = 1'b1;
        floorIdx   = 2'd0;
        if (floor_i == labelF1)      floorIdx = 2'd0;
        else if (floor_i == labelF2) floorIdx = 2'd1;
        else if (floor_i == labelF3) floorIdx = 2'd2;
        else                         floorValid = 1'b0;
    end

    // Clearing at the stopped floor beats a same-cycle press; sos beats everything.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ledClr[i] = floorValid && !moving_i && (floorIdx == 2'(i));
            if (sos_mode_i)     led_d[i] = 1'b0;
            else if (ledClr[i]) led_d[i] = 1'b0;
            else if (press[i])  led_d[i] = 1'b1;
            else                led_d[i] = led_q[i];
        end
    end

    always_comb begin
        above    = 1'b0;
        below    = 1'b0;
        nearUp   = floor_i;
        nearDown = floor_i;
        case (floorIdx)
            2'd0: begin
                above  = led_q[1] | led_q[2];
                nearUp = led_q[1] ? labelF2 : labelF3;
            end
            2'd1: begin
                above    = led_q[2];
                below    = led_q[0];
                nearUp   = labelF3;
                nearDown = labelF1;
            end
            default: begin
                below    = led_q[0] | led_q[1];
                nearDown = led_q[1] ? labelF2 : labelF1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            goal_q  <= labelF1;
        end else begin
            state_q <= state_d;
            goal_q  <= goal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        goal_d  = goal_q;
        if (sos_mode_i) begin
            state_d = IDLE;
            if (floorValid) goal_d = floor_i;
        end else if (!moving_i && floorValid) begin
            case (state_q)
                UP:      state_d = above ? UP   : (below ? DOWN : IDLE);
                DOWN:    state_d = below ? DOWN : (above ? UP   : IDLE);
                default: state_d = above ? UP   : (below ? DOWN : IDLE);
            endcase
            case (state_d)
                UP:      goal_d = nearUp;
                DOWN:    goal_d = nearDown;
                default: goal_d = floor_i;
            endcase
        end
    end

    always_comb begin
        dir_up_o          = (state_q == UP);
        dir_down_o        = (state_q == DOWN);
        led1_o            = led_q[0];
        led2_o            = led_q[1];
        led3_o            = led_q[2];
        goal_floor_o      = goal_q;
        request_pending_o = |led_q;
    end

endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler: expected output vectors are queued as
// each step is driven and popped for comparison once the DUT has clocked.
module tb_call_scheduler;

    localparam logic [1:0] F1 = 2'b00;
    localparam logic [1:0] F2 = 2'b01;
    localparam logic [1:0] F3 = 2'b10;
    localparam logic [1:0] FX = 2'b11;

    logic       clk;
    logic       reset;
    logic       b1, b2, b3;
    logic [1:0] floorIn;
    logic       moving;
    logic       sos;
    logic       led1, led2, led3;
    logic [1:0] goal;
    logic       dirUp, dirDown, reqPending;

    int total = 0;
    int bad   = 0;

    string      tagQ[$];
    logic [8:0] expQ[$];

    call_scheduler #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .button1_i        (b1),
        .button2_i        (b2),
        .button3_i        (b3),
        .floor_i          (floorIn),
        .moving_i         (moving),
        .sos_mode_i       (sos),
        .led1_o           (led1),
        .led2_o           (led2),
        .led3_o           (led3),
        .goal_floor_o     (goal),
        .dir_up_o         (dirUp),
        .dir_down_o       (dirDown),
        .request_pending_o(reqPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {led3, led2, led1, goal[1:0], dir_up, dir_down, request_pending}
    function automatic logic [8:0] mk(input logic [2:0] leds, input logic [1:0] g,
                                      input logic up, input logic down);
        return {leds, g, up, down, |leds};
    endfunction

    task automatic applyStimulus(input logic r, input logic [2:0] btn, input logic [1:0] fl,
                                 input logic mv, input logic s);
        reset   = r;
        {b3, b2, b1} = btn;
        floorIn = fl;
        moving  = mv;
        sos     = s;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushExpect(input string tag, input logic [8:0] e);
        tagQ.push_back(tag);
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        logic [8:0] obs;
        logic [8:0] e;
        string      tag;
        obs = {led3, led2, led1, goal, dirUp, dirDown, reqPending};
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_underflow observed=%b expected=<none>", obs);
        end else begin
            e   = expQ.pop_front();
            tag = tagQ.pop_front();
            assert (obs === e)
            else begin
                bad++;
                $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, e);
            end
        end
    endtask

    initial begin
        applyStimulus(1'b1, 3'b000, F1, 1'b0, 1'b0);
        pushExpect("reset_state", mk(3'b000, F1, 1'b0, 1'b0));
        cycles(2);
        checkOutput();

        // Held button3 at F1: led at cycle 6, sweep up towards F3 at cycle 7.
        applyStimulus(1'b0, 3'b100, F1, 1'b0, 1'b0);
        pushExpect("t1_before_pulse", mk(3'b000, F1, 1'b0, 1'b0));
        cycles(5);
        checkOutput();
        pushExpect("t1_led3_set", mk(3'b100, F1, 1'b0, 1'b0));
        cycles(1);
        checkOutput();
        pushExpect("t1_goal_f3", mk(3'b100, F3, 1'b1, 1'b0));
        cycles(1);
        checkOutput();
        cycles(3);
        applyStimulus(1'b0, 3'b000, F1, 1'b0, 1'b0);
        pushExpect("t1_after_release", mk(3'b100, F3, 1'b1, 1'b0));
        cycles(3);
        checkOutput();

        // Three-cycle glitches on button2, twice, must never light led2.
        applyStimulus(1'b0, 3'b010, F1, 1'b0, 1'b0);
        cycles(3);
        applyStimulus(1'b0, 3'b000, F1, 1'b0, 1'b0);
        pushExpect("t2_glitch", mk(3'b100, F3, 1'b1, 1'b0));
        cycles(4);
        checkOutput();
        applyStimulus(1'b0, 3'b010, F1, 1'b0, 1'b0);
        cycles(3);
        applyStimulus(1'b0, 3'b000, F1, 1'b0, 1'b0);
        pushExpect("t2_reglitch", mk(3'b100, F3, 1'b1, 1'b0));
        cycles(4);
        checkOutput();

        // Call F1 while leaving F1, travel up through F2 to F3, then sweep down.
        applyStimulus(1'b0, 3'b001, F1, 1'b1, 1'b0);
        cycles(8);
        applyStimulus(1'b0, 3'b000, F1, 1'b1, 1'b0);
        pushExpect("t3_led1_moving", mk(3'b101, F3, 1'b1, 1'b0));
        cycles(1);
        checkOutput();
        applyStimulus(1'b0, 3'b000, F2, 1'b1, 1'b0);
        pushExpect("t3_travel_hold", mk(3'b101, F3, 1'b1, 1'b0));
        cycles(2);
        checkOutput();
        applyStimulus(1'b0, 3'b000, F2, 1'b0, 1'b0);
        pushExpect("t3_stop_f2", mk(3'b101, F3, 1'b1, 1'b0));
        cycles(1);
        checkOutput();
        applyStimulus(1'b0, 3'b000, F3, 1'b1, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 3'b000, F3, 1'b0, 1'b0);
        pushExpect("t3_stop_f3", mk(3'b001, F1, 1'b0, 1'b1));
        cycles(1);
        checkOutput();
        pushExpect("t3_down_hold", mk(3'b001, F1, 1'b0, 1'b1));
        cycles(1);
        checkOutput();
        applyStimulus(1'b0, 3'b000, F1, 1'b1, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 3'b000, F1, 1'b0, 1'b0);
        pushExpect("t3_arrive_f1", mk(3'b000, F1, 1'b0, 1'b0));
        cycles(1);
        checkOutput();

        // A call at the stopped floor never lights.
        applyStimulus(1'b0, 3'b001, F1, 1'b0, 1'b0);
        pushExpect("t4_same_floor_pulse", mk(3'b000, F1, 1'b0, 1'b0));
        cycles(6);
        checkOutput();
        pushExpect("t4_same_floor_held", mk(3'b000, F1, 1'b0, 1'b0));
        cycles(3);
        checkOutput();
        applyStimulus(1'b0, 3'b000, F1, 1'b0, 1'b0);

        // Two calls above, nearest chosen; sos then wipes them and re-targets the goal.
        applyStimulus(1'b0, 3'b110, F1, 1'b0, 1'b0);
        cycles(8);
        applyStimulus(1'b0, 3'b000, F1, 1'b0, 1'b0);
        pushExpect("t5_nearest_up", mk(3'b110, F2, 1'b1, 1'b0));
        cycles(1);
        checkOutput();
        applyStimulus(1'b0, 3'b000, F1, 1'b1, 1'b0);
        pushExpect("t5_moving_hold", mk(3'b110, F2, 1'b1, 1'b0));
        cycles(1);
        checkOutput();
        applyStimulus(1'b0, 3'b000, F1, 1'b1, 1'b1);
        pushExpect("t5_sos_cancel", mk(3'b000, F1, 1'b0, 1'b0));
        cycles(1);
        checkOutput();
        applyStimulus(1'b0, 3'b100, F1, 1'b1, 1'b1);
        cycles(8);
        applyStimulus(1'b0, 3'b000, F1, 1'b1, 1'b0);
        pushExpect("t5_sos_press_ignored", mk(3'b000, F1, 1'b0, 1'b0));
        cycles(2);
        checkOutput();

        // Reset mid-sweep, then an invalid floor freezes the FSM while calls still latch.
        applyStimulus(1'b0, 3'b100, F2, 1'b0, 1'b0);
        cycles(8);
        applyStimulus(1'b0, 3'b000, F2, 1'b1, 1'b0);
        pushExpect("t6_sweep_up", mk(3'b100, F3, 1'b1, 1'b0));
        cycles(1);
        checkOutput();
        applyStimulus(1'b1, 3'b000, F2, 1'b1, 1'b0);
        pushExpect("t6_reset_mid_sweep", mk(3'b000, F1, 1'b0, 1'b0));
        cycles(1);
        checkOutput();
        applyStimulus(1'b0, 3'b100, FX, 1'b0, 1'b0);
        cycles(8);
        applyStimulus(1'b0, 3'b000, FX, 1'b0, 1'b0);
        pushExpect("t6_invalid_floor", mk(3'b100, F1, 1'b0, 1'b0));
        cycles(1);
        checkOutput();

        total++;
        assert (expQ.size() == 0)
        else begin
            bad++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
